modn_updown_counter: RTL and testbench

- Loadable modulo-N counter counting in either direction; the down-counting complement to the existing mod-6 up counter.
- Used for countdown timers, cascaded BCD-style digit chains and cycle dividers.
- Terminal-count output is combinational so instances cascade synchronously, with the lower digit's tc driving the next digit's en.
- Default parameters give the mod-6 (0..5) range.

---
 rtl/modn_cnt_pkg.sv | 15 +
 rtl/modn_limit_detect.sv | 23 ++
 rtl/modn_updown_counter.sv | 73 +++++++
 tb/tb_modn_updown_counter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/modn_cnt_pkg.sv
// modn_cnt_pkg: direction constants and wrapped next-count helper shared by the mod-N counter slice.
package modn_cnt_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Wrap-around successor of q within 0..modulus-1 in the requested direction.
    function automatic int unsigned next_count(input int unsigned q, input logic up_dn,
                                               input int unsigned modulus);
        if (up_dn == DIR_UP)
            return (q == modulus - 32'd1) ? 32'd0 : q + 32'd1;
        return (q == 32'd0) ? modulus - 32'd1 : q - 32'd1;
    endfunction

endpackage

// File: rtl/modn_limit_detect.sv
// modn_limit_detect: combinational limit flags and cascade terminal count for the mod-N counter.
module modn_limit_detect
    import modn_cnt_pkg::*;
#(
    parameter int MODULUS = 6,
    parameter int WIDTH   = 3
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up_dn,
    input  logic             en,
    input  logic             load,
    output logic             at_max,
    output logic             at_zero,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    assign at_max  = q == MAX;
    assign at_zero = q == '0;
    assign tc      = en & ~load & (((up_dn == DIR_UP) & at_max) | ((up_dn == DIR_DN) & at_zero));

endmodule

// File: rtl/modn_updown_counter.sv
// modn_updown_counter: loadable modulo-N up/down counter with cascadable tc and wrap/load_err pulses.
// Define MODN_UPDOWN_COUNTER_SATURATE_EN to pin at the limits instead of wrapping (wrap becomes a sat pulse).
module modn_updown_counter
    import modn_cnt_pkg::*;
#(
    parameter int MODULUS = 6,
    parameter int WIDTH   = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic             at_max;
    logic             at_zero;
    logic             limit;
    logic             bad;
    logic             pulse;
    logic [WIDTH-1:0] wrapped;
    logic [WIDTH-1:0] step;

    modn_limit_detect #(.MODULUS(MODULUS), .WIDTH(WIDTH)) u_limit (
        .q      (q),
        .up_dn  (up_dn),
        .en     (en),
        .load   (load),
        .at_max (at_max),
        .at_zero(at_zero),
        .tc     (tc)
    );

    assign limit   = (up_dn == DIR_UP) ? at_max : at_zero;
    assign bad     = load_val > MAX;
    assign wrapped = WIDTH'(next_count(32'(q), up_dn, MODULUS));

`ifdef MODN_UPDOWN_COUNTER_SATURATE_EN
    // pinned remembers a limit hit on the previous edge so the sat pulse fires only once.
    logic pinned;
    assign step  = limit ? q : wrapped;
    assign pulse = en & ~load & limit & ~pinned;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pinned <= 1'b0;
        else
            pinned <= en & ~load & limit;
    end
`else
    assign step  = wrapped;
    assign pulse = en & ~load & limit;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q        <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            q        <= load ? (bad ? '0 : load_val) : (en ? step : q);
            wrap     <= pulse;
            load_err <= load & bad;
        end
    end

endmodule

// File: tb/tb_modn_updown_counter.sv
// tb_modn_updown_counter: randomized scoreboard bench for modn_updown_counter plus a two-digit cascade.
module tb_modn_updown_counter;

    localparam int N = 6;
    localparam int W = 3;
`ifdef MODN_UPDOWN_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic         tc;
        logic [W-1:0] q;
        logic         wrap;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         en, up_dn, load;
    logic [W-1:0] load_val;
    logic [W-1:0] q;
    logic         tc, wrap, load_err;

    logic         c_en, c_up;
    logic [W-1:0] lo_q, hi_q;
    logic         lo_tc, hi_tc, lo_wrap, hi_wrap, lo_err, hi_err;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   m_q    = 0;
    bit   m_prev = 1'b0;

    always #5 clk = ~clk;

    modn_updown_counter #(.MODULUS(N), .WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q), .tc(tc), .wrap(wrap), .load_err(load_err)
    );

    modn_updown_counter #(.MODULUS(N), .WIDTH(W)) lo (
        .clk(clk), .reset_n(reset_n), .en(c_en), .up_dn(c_up), .load(1'b0),
        .load_val(3'd0), .q(lo_q), .tc(lo_tc), .wrap(lo_wrap), .load_err(lo_err)
    );

    modn_updown_counter #(.MODULUS(N), .WIDTH(W)) hi (
        .clk(clk), .reset_n(reset_n), .en(lo_tc), .up_dn(c_up), .load(1'b0),
        .load_val(3'd0), .q(hi_q), .tc(hi_tc), .wrap(hi_wrap), .load_err(hi_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain modular arithmetic on an integer count.
    task automatic step(input bit l, input int lv, input bit e, input bit u);
        exp_t x;
        bit   at_lim;
        @(negedge clk);
        load = l; load_val = W'(lv); en = e; up_dn = u;
        at_lim = u ? (m_q == N - 1) : (m_q == 0);
        x.tc   = e && !l && at_lim;
        x.err  = l && lv >= N;
        if (l)
            m_q = (lv < N) ? lv : 0;
        else if (e && !(SAT && at_lim))
            m_q = u ? (m_q + 1) % N : (m_q + N - 1) % N;
        x.wrap = SAT ? (x.tc && !m_prev) : x.tc;
        m_prev = x.tc;
        x.q    = W'(m_q);
        sbq.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        logic tc_s;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                tc_s = tc;
                @(posedge clk);
                #1;
                x = sbq.pop_front();
                chk("tc", int'(tc_s), int'(x.tc));
                chk("q", int'(q), int'(x.q));
                chk("wrap", int'(wrap), int'(x.wrap));
                chk("load_err", int'(load_err), int'(x.err));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        reset_n = 1'b0; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_val = '0;
        c_en = 1'b0; c_up = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q", int'(q), 0);
        chk("reset_wrap", int'(wrap), 0);
        chk("reset_err", int'(load_err), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(1, 2, 0, 0);
        repeat (4) step(0, 0, 1, 0);
        step(1, 4, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(1, 5, 0, 0);
        step(1, 3, 1, 1);
        step(1, 7, 1, 0);
        step(0, 0, 0, 0);
        step(1, 4, 0, 1);
        repeat (3) step(0, 0, 1, 1);
        step(1, 1, 0, 0);
        repeat (2) step(0, 0, 1, 0);
        for (int i = 0; i < 400; i++)
            step(($urandom % 8) == 0, int'($urandom_range(0, 7)), ($urandom % 4) != 0, 1'($urandom));
        step(1, 4, 0, 0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_q", int'(q), 0);
        chk("async_wrap", int'(wrap), 0);
        chk("async_err", int'(load_err), 0);
        m_q = 0; m_prev = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        c_en = 1'b1; c_up = 1'b0;
        #1;
        chk("cascade_lo_tc", int'(lo_tc), 1);
        @(posedge clk);
        #1;
        chk("cascade_lo", int'(lo_q), SAT ? 0 : N - 1);
        chk("cascade_hi", int'(hi_q), SAT ? 0 : N - 1);
        @(negedge clk);
        c_en = 1'b0;
        @(negedge clk);
        if (sbq.size() != 0) chk("scoreboard_drain", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
